// File: rtl/ft245rl_device_model.sv
// ---------------------------------------------------------------------------
// ft245rl_device_model
//   Synthesizable stand-in for the FT245RL USB FIFO chip. It plays the device
//   side of the parallel FIFO bus so an FPGA-side FT245RL controller can be
//   exercised on-chip (loopback, self-test) or in simulation without USB.
//
//   RX FIFO : host pushes bytes (h_wd/h_we); controller reads them via RD#.
//   TX FIFO : controller writes bytes via WR; host pops them (h_rd/h_re).
//
// Ports
//   clk, rst            system clock, async active-high reset
//   usb_d_i             bus data from controller (sampled on WR fall)
//   usb_d_o, usb_d_oe   bus data to controller and its drive enable
//   usb_rdn             RD#, active-low read strobe
//   usb_wr              WR, active-high write strobe
//   usb_rxfn            RXF#, 0 = byte available for the controller
//   usb_txen            TXE#, 0 = room for a controller write
//   usb_pwen            PWREN#, 0 = device configured
//   h_wd, h_we, h_ful   host push side of the RX FIFO
//   h_rd, h_re, h_emp   host pop side of the TX FIFO (first-word fall-through)
//   udf_err, ovf_err    sticky: read while RX empty / write while TX full
// ---------------------------------------------------------------------------
module ft245rl_device_model #(
    parameter int AW       = 4,
    parameter int PWEN_DLY = 16,
    parameter int RXF_PRE  = 2,
    parameter int TXE_PRE  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] usb_d_i,
    output logic [7:0] usb_d_o,
    output logic       usb_d_oe,
    input  logic       usb_rdn,
    input  logic       usb_wr,
    output logic       usb_rxfn,
    output logic       usb_txen,
    output logic       usb_pwen,
    input  logic [7:0] h_wd,
    input  logic       h_we,
    output logic       h_ful,
    output logic [7:0] h_rd,
    input  logic       h_re,
    output logic       h_emp,
    output logic       udf_err,
    output logic       ovf_err
);
    localparam int DEPTH = 1 << AW;
    localparam int PW    = $clog2(PWEN_DLY + 2);
    localparam int RCW   = $clog2(RXF_PRE + 2);
    localparam int TCW   = $clog2(TXE_PRE + 2);

    typedef enum logic [1:0] {R_IDLE, R_DRV, R_PRE} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_STB, W_PRE} wr_state_t;

    rd_state_t rs, rs_n;
    wr_state_t ws, ws_n;

    logic           rdn_q, wr_q;
    logic [PW-1:0]  pwen_cnt;
    logic           oe_q, oe_n;
    logic           rd_dat, rd_dat_n;   // RX had data when the read strobe began
    logic [RCW-1:0] rcnt, rcnt_n;
    logic [TCW-1:0] tcnt, tcnt_n;
    logic           rxfn_n, txen_n, udf_n, ovf_n;
    logic [7:0]     dout_n;

    // ---------------- FIFOs ----------------
    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];
    logic [AW:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic rx_emp, rx_ful, tx_emp, tx_ful;
    logic rx_push, rx_pop, tx_push, tx_pop;

    assign rx_emp = (rx_wp == rx_rp);
    assign rx_ful = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign tx_emp = (tx_wp == tx_rp);
    assign tx_ful = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);

    assign rx_push = h_we && !rx_ful;
    assign tx_pop  = h_re && !tx_emp;

    assign h_ful = rx_ful;
    assign h_emp = tx_emp;
    assign h_rd  = tx_mem[tx_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= h_wd;
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= usb_d_i;
    end

    // Bus drive is released combinationally whenever the controller strobes
    // WR, so the two sides never fight; reset clears oe_q asynchronously.
    assign usb_d_oe = oe_q & ~usb_wr;

    // Power-good: held high until the counter reaches PWEN_DLY, then sticks low.
    assign usb_pwen = (pwen_cnt != PW'(PWEN_DLY));

    // ---------------- read FSM ----------------
    always_comb begin
        rs_n     = rs;
        rxfn_n   = usb_rxfn;
        dout_n   = usb_d_o;
        oe_n     = oe_q;
        udf_n    = udf_err;
        rd_dat_n = rd_dat;
        rcnt_n   = rcnt;
        rx_pop   = 1'b0;
        if (usb_pwen) begin
            rs_n   = R_IDLE;
            rxfn_n = 1'b1;
            oe_n   = 1'b0;
        end else begin
            case (rs)
                R_IDLE: begin
                    rxfn_n = rx_emp;
                    if (!usb_rdn) begin
                        rs_n     = R_DRV;
                        rxfn_n   = 1'b1;
                        oe_n     = 1'b1;
                        rd_dat_n = !rx_emp;
                        if (rx_emp) begin
                            dout_n = 8'h00;
                            udf_n  = 1'b1;
                        end else begin
                            dout_n = rx_mem[rx_rp[AW-1:0]];
                        end
                    end
                end
                R_DRV: begin
                    // RD# rising edge: release bus, consume the byte
                    if (!rdn_q && usb_rdn) begin
                        oe_n   = 1'b0;
                        rx_pop = rd_dat;
                        rcnt_n = RCW'(RXF_PRE);
                        rs_n   = R_PRE;
                    end
                end
                R_PRE: begin
                    if (rcnt <= RCW'(1)) rs_n = R_IDLE;
                    else                 rcnt_n = rcnt - 1'b1;
                end
                default: rs_n = R_IDLE;
            endcase
        end
    end

    // ---------------- write FSM ----------------
    always_comb begin
        ws_n    = ws;
        txen_n  = usb_txen;
        ovf_n   = ovf_err;
        tcnt_n  = tcnt;
        tx_push = 1'b0;
        if (usb_pwen) begin
            ws_n   = W_IDLE;
            txen_n = 1'b1;
        end else begin
            case (ws)
                W_IDLE: begin
                    txen_n = tx_ful;
                    if (usb_wr) ws_n = W_STB;
                end
                W_STB: begin
                    // WR falling edge: usb_d_i is captured this very cycle.
                    // Fullness is judged before any same-cycle host pop.
                    if (wr_q && !usb_wr) begin
                        if (tx_ful) ovf_n   = 1'b1;
                        else        tx_push = 1'b1;
                        txen_n = 1'b1;
                        tcnt_n = TCW'(TXE_PRE);
                        ws_n   = W_PRE;
                    end
                end
                W_PRE: begin
                    if (tcnt <= TCW'(1)) ws_n = W_IDLE;
                    else                 tcnt_n = tcnt - 1'b1;
                end
                default: ws_n = W_IDLE;
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdn_q    <= 1'b1;
            wr_q     <= 1'b0;
            pwen_cnt <= '0;
            rs       <= R_IDLE;
            ws       <= W_IDLE;
            usb_rxfn <= 1'b1;
            usb_txen <= 1'b1;
            usb_d_o  <= 8'h00;
            oe_q     <= 1'b0;
            udf_err  <= 1'b0;
            ovf_err  <= 1'b0;
            rd_dat   <= 1'b0;
            rcnt     <= '0;
            tcnt     <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            tx_wp    <= '0;
            tx_rp    <= '0;
        end else begin
            rdn_q    <= usb_rdn;
            wr_q     <= usb_wr;
            if (usb_pwen) pwen_cnt <= pwen_cnt + 1'b1;
            rs       <= rs_n;
            ws       <= ws_n;
            usb_rxfn <= rxfn_n;
            usb_txen <= txen_n;
            usb_d_o  <= dout_n;
            oe_q     <= oe_n;
            udf_err  <= udf_n;
            ovf_err  <= ovf_n;
            rd_dat   <= rd_dat_n;
            rcnt     <= rcnt_n;
            tcnt     <= tcnt_n;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end
endmodule

// File: tb/tb_ft245rl_device_model.sv
// ---------------------------------------------------------------------------
// tb_ft245rl_device_model
//   Scoreboard bench: drivers act as the FPGA-side controller and the host,
//   pushing expected bytes into queues; negedge monitors compare whatever the
//   model presents on the bus (read data) or the host pop port.
// ---------------------------------------------------------------------------
module tb_ft245rl_device_model;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] usb_d_i = 8'h00;
    logic [7:0] usb_d_o;
    logic       usb_d_oe;
    logic       usb_rdn = 1'b1;
    logic       usb_wr  = 1'b0;
    logic       usb_rxfn, usb_txen, usb_pwen;
    logic [7:0] h_wd = 8'h00;
    logic       h_we = 1'b0;
    logic       h_ful;
    logic [7:0] h_rd;
    logic       h_re = 1'b0;
    logic       h_emp;
    logic       udf_err, ovf_err;

    ft245rl_device_model dut (
        .clk(clk), .rst(rst),
        .usb_d_i(usb_d_i), .usb_d_o(usb_d_o), .usb_d_oe(usb_d_oe),
        .usb_rdn(usb_rdn), .usb_wr(usb_wr),
        .usb_rxfn(usb_rxfn), .usb_txen(usb_txen), .usb_pwen(usb_pwen),
        .h_wd(h_wd), .h_we(h_we), .h_ful(h_ful),
        .h_rd(h_rd), .h_re(h_re), .h_emp(h_emp),
        .udf_err(udf_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: FIFO contents as byte queues plus expected sticky flags.
    logic [7:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    bit         exp_udf = 1'b0;
    bit         exp_ovf = 1'b0;
    int         n_rd = 0;
    int         n_tx = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- monitors ----------------
    int         rd_low = 0;
    logic [7:0] rd_exp;
    always @(negedge clk) begin
        if (usb_rdn) rd_low = 0;
        else begin
            rd_low++;
            // second low sample: one clock after RD# fell, data must be on the bus
            if (rd_low == 2) begin
                if (exp_rd.size() > 0) rd_exp = exp_rd.pop_front();
                else begin
                    rd_exp  = 8'h00;
                    exp_udf = 1'b1;
                end
                chk("rd_data", usb_d_o, rd_exp);
                chk("rd_oe", usb_d_oe, !usb_wr);
                n_rd++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && h_re && !h_emp) begin
            if (exp_tx.size() == 0) begin
                n_chk++;
                $display("FAIL tx_pop: got %0h with no byte expected", h_rd);
            end else begin
                chk("tx_data", h_rd, exp_tx.pop_front());
            end
            n_tx++;
        end
    end

    // ---------------- drivers ----------------
    task automatic host_push(input logic [7:0] b);
        @(posedge clk); #1;
        h_wd = b; h_we = 1'b1;
        @(posedge clk); #1;
        h_we = 1'b0;
        exp_rd.push_back(b);
    endtask

    task automatic host_pop();
        @(posedge clk); #1;
        h_re = 1'b1;
        @(posedge clk); #1;
        h_re = 1'b0;
    endtask

    task automatic bus_read(input int hold);
        @(posedge clk); #1;
        usb_rdn = 1'b0;
        repeat (hold) @(posedge clk);
        #1 usb_rdn = 1'b1;
    endtask

    task automatic bus_write(input logic [7:0] b);
        if (exp_tx.size() < DEPTH) exp_tx.push_back(b);
        else exp_ovf = 1'b1;
        @(posedge clk); #1;
        usb_d_i = b; usb_wr = 1'b1;
        @(posedge clk); #1;
        usb_wr = 1'b0;
        @(posedge clk); #1;
        usb_d_i = ~b;
    endtask

    task automatic wait_rxf();
        int t = 0;
        @(negedge clk);
        while (usb_rxfn !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        chk("rxfn_low", usb_rxfn, 0);
    endtask

    task automatic wait_txe();
        int t = 0;
        @(negedge clk);
        while (usb_txen !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        chk("txen_low", usb_txen, 0);
    endtask

    task automatic wait_room();
        int t = 0;
        @(negedge clk);
        while (h_ful !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        chk("h_ful_low", h_ful, 0);
    endtask

    task automatic wait_data();
        int t = 0;
        @(negedge clk);
        while (h_emp !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        chk("h_emp_low", h_emp, 0);
    endtask

    task automatic powerup();
        rst = 1'b1;
        exp_rd.delete(); exp_tx.delete();
        exp_udf = 1'b0; exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_d_o",  usb_d_o,  8'h00);
        chk("rst_oe",   usb_d_oe, 0);
        chk("rst_rxfn", usb_rxfn, 1);
        chk("rst_txen", usb_txen, 1);
        chk("rst_pwen", usb_pwen, 1);
        chk("rst_hful", h_ful,    0);
        chk("rst_hemp", h_emp,    1);
        chk("rst_udf",  udf_err,  0);
        chk("rst_ovf",  ovf_err,  0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (16) @(negedge clk);       // 15 clocks since release
        chk("pwen_hi_15", usb_pwen, 1);
        @(negedge clk);                   // 16 clocks
        chk("pwen_lo_16", usb_pwen, 0);
        repeat (2) @(negedge clk);
        chk("pu_rxfn", usb_rxfn, 1);
        chk("pu_txen", usb_txen, 0);
    endtask

    // ---------------- full-duplex workers ----------------
    task automatic dup_pusher();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_room();
            host_push(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic dup_reader();
        for (int i = 0; i < 40; i++) begin
            wait_rxf();
            bus_read($urandom_range(2, 3));
        end
    endtask

    task automatic dup_writer();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            wait_txe();
            bus_write(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic dup_popper();
        int got = 0;
        int t   = 0;
        while (got < 40 && t < 6000) begin
            @(negedge clk);
            t++;
            if (!h_emp && $urandom_range(0, 1) == 1) begin
                host_pop();
                got++;
            end
        end
        chk("dup_pops", got, 40);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rd0, tx0;

        // Power-up
        powerup();

        // Single read
        host_push(8'hA5);
        wait_rxf();
        rd0 = n_rd;
        bus_read(3);
        repeat (2) @(negedge clk);
        chk("sr_oe_off", usb_d_oe, 0);
        chk("sr_rxfn_pre0", usb_rxfn, 1);
        @(negedge clk);
        chk("sr_rxfn_pre1", usb_rxfn, 1);
        repeat (3) @(negedge clk);
        chk("sr_rxfn_empty", usb_rxfn, 1);
        chk("sr_hful", h_ful, 0);
        chk("sr_reads", n_rd - rd0, 1);

        // Write burst to full, then overflow
        for (int i = 0; i < 16; i++) begin
            wait_txe();
            bus_write(8'(i));
        end
        repeat (6) @(negedge clk);
        chk("wb_txen_full", usb_txen, 1);
        chk("wb_ovf_pre", ovf_err, 0);
        bus_write(8'h10);
        repeat (2) @(negedge clk);
        chk("wb_ovf", ovf_err, exp_ovf);
        tx0 = n_tx;
        for (int i = 0; i < 16; i++) begin
            wait_data();
            host_pop();
        end
        repeat (2) @(negedge clk);
        chk("wb_pops", n_tx - tx0, 16);
        chk("wb_hemp", h_emp, 1);
        chk("wb_exp_left", exp_tx.size(), 0);

        // Underflow
        chk("uf_rxfn", usb_rxfn, 1);
        bus_read(2);
        repeat (3) @(negedge clk);
        chk("uf_flag", udf_err, exp_udf);
        host_push(8'h3C);
        wait_rxf();
        bus_read(2);
        repeat (6) @(negedge clk);
        chk("uf_ptr_ok", usb_rxfn, 1);

        // Reset mid-read with 3 bytes queued
        host_push(8'h11); host_push(8'h22); host_push(8'h33);
        wait_rxf();
        @(posedge clk); #1 usb_rdn = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_oe_on", usb_d_oe, 1);
        #1 rst = 1'b1;
        #1;
        chk("mr_oe_async", usb_d_oe, 0);
        chk("mr_pwen", usb_pwen, 1);
        chk("mr_rxfn", usb_rxfn, 1);
        chk("mr_hful", h_ful, 0);
        usb_rdn = 1'b1;
        powerup();
        host_push(8'h5C);
        wait_rxf();
        bus_read(2);
        repeat (6) @(negedge clk);
        chk("mr_only_new", usb_rxfn, 1);

        // Full duplex with pointer wrap
        rd0 = n_rd; tx0 = n_tx;
        fork
            dup_pusher();
            dup_reader();
            dup_writer();
            dup_popper();
        join
        repeat (10) @(negedge clk);
        chk("fd_reads", n_rd - rd0, 40);
        chk("fd_pops",  n_tx - tx0, 40);
        chk("fd_rd_left", exp_rd.size(), 0);
        chk("fd_tx_left", exp_tx.size(), 0);
        chk("fd_udf", udf_err, exp_udf);
        chk("fd_ovf", ovf_err, exp_ovf);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
